// File: rtl/tap_ctrl_if.sv
// JTAG pin bundle between the pad ring (master) and the TAP controller (slave).
// TMS/TDI sampled on posedge TCLK; TDO/TDO_EN launched on negedge TCLK.
interface tap_ctrl_if;
  logic TMS;
  logic TDI;
  logic TDO;
  logic TDO_EN;

  modport master (output TMS, output TDI, input TDO, input TDO_EN);
  modport slave  (input TMS, input TDI, output TDO, output TDO_EN);
endinterface

// File: rtl/tap_ctrl.sv
// IEEE 1149.1 TAP: FSM, IR, bypass, user chain select; IDCODE register present when TAP_IDCODE_EN is defined.
// State/capture/shift on posedge TCLK, ir and TDO on negedge TCLK; no backpressure (pin-paced).
module tap_ctrl #(
  parameter int          IR_W       = 4,
  parameter int          NUM_DR     = 2,
  parameter logic [31:0] IDCODE_VAL = 32'h0000_0001
) (
  input  logic              TCLK,
  input  logic              TRSTN,
  tap_ctrl_if.slave         jtag,
  output logic [3:0]        tap_state,
  output logic [IR_W-1:0]   ir,
  output logic [NUM_DR-1:0] dr_sel,
  output logic              CaptureDR,
  output logic              ShiftDR,
  output logic              UpdateDR,
  input  logic [NUM_DR-1:0] user_tdo
);

  if (IR_W < 2 || NUM_DR < 1 || NUM_DR > 8 || (1 << IR_W) < (NUM_DR + 3) ||
      IDCODE_VAL[0] != 1'b1) begin : g_bad_param
    $error("tap_ctrl: illegal parameter combination");
  end

  typedef enum logic [3:0] {
    S_TLR      = 4'd0,
    S_IDLE     = 4'd1,
    S_SEL_DR   = 4'd2,
    S_CAP_DR   = 4'd3,
    S_SHI_DR   = 4'd4,
    S_EXIT1_DR = 4'd5,
    S_PAUSE_DR = 4'd6,
    S_EXIT2_DR = 4'd7,
    S_UPD_DR   = 4'd8,
    S_SEL_IR   = 4'd9,
    S_CAP_IR   = 4'd10,
    S_SHI_IR   = 4'd11,
    S_EXIT1_IR = 4'd12,
    S_PAUSE_IR = 4'd13,
    S_EXIT2_IR = 4'd14,
    S_UPD_IR   = 4'd15
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [IR_W-1:0] ir_sr;
  logic            bypass_bit;
  logic            dr_tdo;
  logic            user_bit;
  logic            tdo_q;
  logic            tdo_en_q;

  always_ff @(posedge TCLK or negedge TRSTN) begin
    if (!TRSTN) state <= S_TLR;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = S_TLR;
    case (state)
      S_TLR:      state_nxt = jtag.TMS ? S_TLR      : S_IDLE;
      S_IDLE:     state_nxt = jtag.TMS ? S_SEL_DR   : S_IDLE;
      S_SEL_DR:   state_nxt = jtag.TMS ? S_SEL_IR   : S_CAP_DR;
      S_CAP_DR:   state_nxt = jtag.TMS ? S_EXIT1_DR : S_SHI_DR;
      S_SHI_DR:   state_nxt = jtag.TMS ? S_EXIT1_DR : S_SHI_DR;
      S_EXIT1_DR: state_nxt = jtag.TMS ? S_UPD_DR   : S_PAUSE_DR;
      S_PAUSE_DR: state_nxt = jtag.TMS ? S_EXIT2_DR : S_PAUSE_DR;
      S_EXIT2_DR: state_nxt = jtag.TMS ? S_UPD_DR   : S_SHI_DR;
      S_UPD_DR:   state_nxt = jtag.TMS ? S_SEL_DR   : S_IDLE;
      S_SEL_IR:   state_nxt = jtag.TMS ? S_TLR      : S_CAP_IR;
      S_CAP_IR:   state_nxt = jtag.TMS ? S_EXIT1_IR : S_SHI_IR;
      S_SHI_IR:   state_nxt = jtag.TMS ? S_EXIT1_IR : S_SHI_IR;
      S_EXIT1_IR: state_nxt = jtag.TMS ? S_UPD_IR   : S_PAUSE_IR;
      S_PAUSE_IR: state_nxt = jtag.TMS ? S_EXIT2_IR : S_PAUSE_IR;
      S_EXIT2_IR: state_nxt = jtag.TMS ? S_UPD_IR   : S_SHI_IR;
      S_UPD_IR:   state_nxt = jtag.TMS ? S_SEL_DR   : S_IDLE;
      default:    state_nxt = S_TLR;
    endcase
  end

  assign tap_state = state;
  assign CaptureDR = (state == S_CAP_DR);
  assign ShiftDR   = (state == S_SHI_DR);
  assign UpdateDR  = (state == S_UPD_DR);

  // Capture value 01 in the low IR bits is the 1149.1 fixed pattern for board-level IR integrity checks.
  always_ff @(posedge TCLK or negedge TRSTN) begin
    if (!TRSTN) begin
      ir_sr      <= '0;
      bypass_bit <= 1'b0;
    end else begin
      case (state)
        S_CAP_IR: ir_sr <= IR_W'(1);
        S_SHI_IR: ir_sr <= {jtag.TDI, ir_sr[IR_W-1:1]};
        default:  ir_sr <= ir_sr;
      endcase
      if (state == S_CAP_DR)      bypass_bit <= 1'b0;
      else if (state == S_SHI_DR) bypass_bit <= jtag.TDI;
    end
  end

  always_comb begin
    dr_sel = '0;
    for (int k = 0; k < NUM_DR; k++) dr_sel[k] = (ir == IR_W'(k + 2));
  end

  assign user_bit = |(dr_sel & user_tdo);

`ifdef TAP_IDCODE_EN
  localparam logic [IR_W-1:0] IR_RST = IR_W'(1);

  logic [31:0] idcode_sr;
  logic        sel_idcode;

  assign sel_idcode = (ir == IR_W'(1));

  // Left unreset on purpose: every read passes through CapDR, which reloads it.
  always_ff @(posedge TCLK) begin
    if (sel_idcode) begin
      if (state == S_CAP_DR)      idcode_sr <= IDCODE_VAL;
      else if (state == S_SHI_DR) idcode_sr <= {jtag.TDI, idcode_sr[31:1]};
    end
  end

  assign dr_tdo = sel_idcode ? idcode_sr[0] : ((|dr_sel) ? user_bit : bypass_bit);
`else
  localparam logic [IR_W-1:0] IR_RST = '1;

  assign dr_tdo = (|dr_sel) ? user_bit : bypass_bit;
`endif

  // Negedge update keeps ir stable across the following posedge, so chains never see a half-changed select.
  always_ff @(negedge TCLK or negedge TRSTN) begin
    if (!TRSTN) begin
      ir       <= IR_RST;
      tdo_q    <= 1'b0;
      tdo_en_q <= 1'b0;
    end else begin
      if (state == S_TLR)         ir <= IR_RST;
      else if (state == S_UPD_IR) ir <= ir_sr;
      tdo_en_q <= (state == S_SHI_DR) || (state == S_SHI_IR);
      if (state == S_SHI_DR)      tdo_q <= dr_tdo;
      else if (state == S_SHI_IR) tdo_q <= ir_sr[0];
    end
  end

  assign jtag.TDO    = tdo_q;
  assign jtag.TDO_EN = tdo_en_q;

endmodule

// File: tb/tb_tap_ctrl.sv
// Directed bench for tap_ctrl: table-driven FSM walk plus hand sequences for IR/DR scans and reset abort.
module tb_tap_ctrl;
  localparam int          IR_W   = 4;
  localparam int          NUM_DR = 2;
  localparam logic [31:0] IDV    = 32'hA5A5_1235;
`ifdef TAP_IDCODE_EN
  localparam logic [3:0]  IR_RST = 4'b0001;
`else
  localparam logic [3:0]  IR_RST = 4'b1111;
`endif

  logic              TCLK = 1'b0;
  logic              TRSTN;
  logic [3:0]        tap_state;
  logic [IR_W-1:0]   ir;
  logic [NUM_DR-1:0] dr_sel;
  logic              CaptureDR, ShiftDR, UpdateDR;
  logic [NUM_DR-1:0] user_tdo;

  tap_ctrl_if jtag_bus ();

  tap_ctrl #(.IR_W(IR_W), .NUM_DR(NUM_DR), .IDCODE_VAL(IDV)) dut (
    .TCLK      (TCLK),
    .TRSTN     (TRSTN),
    .jtag      (jtag_bus),
    .tap_state (tap_state),
    .ir        (ir),
    .dr_sel    (dr_sel),
    .CaptureDR (CaptureDR),
    .ShiftDR   (ShiftDR),
    .UpdateDR  (UpdateDR),
    .user_tdo  (user_tdo)
  );

  always #5 TCLK = ~TCLK;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic       tms;
    logic [3:0] st;
    logic [2:0] strobes;  // {CaptureDR, ShiftDR, UpdateDR}
    logic       en;
  } vec_t;

  vec_t walk[30];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive pins after a negedge, return just after the following negedge.
  task automatic step(input logic tms, input logic tdi);
    jtag_bus.TMS = tms;
    jtag_bus.TDI = tdi;
    @(posedge TCLK);
    @(negedge TCLK);
    #1;
  endtask

  task automatic load_ir(input logic [3:0] v, output logic [3:0] cap);
    cap = '0;
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    cap[0] = jtag_bus.TDO;
    for (int i = 0; i < 4; i++) begin
      step(i == 3, v[i]);
      if (i < 3) cap[i+1] = jtag_bus.TDO;
    end
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
  endtask

  task automatic dr_scan(input int n, input logic [31:0] pat,
                         output logic [31:0] got, output logic en_all, output logic en_exit);
    got = '0;
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    got[0] = jtag_bus.TDO;
    en_all = jtag_bus.TDO_EN;
    for (int i = 1; i <= n; i++) begin
      step(i == n, pat[i-1]);
      if (i < n) begin
        got[i] = jtag_bus.TDO;
        en_all = en_all & jtag_bus.TDO_EN;
      end
    end
    en_exit = jtag_bus.TDO_EN;
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
  endtask

  initial begin
    #200000;
    n_bad++;
    $display("FAIL watchdog: simulation did not complete within time budget");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] got;
    logic [3:0]  cap;
    logic        en_all, en_exit;
    logic [31:0] pat;

    walk[0]  = '{1'b0, 4'd1,  3'b000, 1'b0};  walk[1]  = '{1'b1, 4'd2,  3'b000, 1'b0};
    walk[2]  = '{1'b0, 4'd3,  3'b100, 1'b0};  walk[3]  = '{1'b0, 4'd4,  3'b010, 1'b1};
    walk[4]  = '{1'b1, 4'd5,  3'b000, 1'b0};  walk[5]  = '{1'b0, 4'd6,  3'b000, 1'b0};
    walk[6]  = '{1'b1, 4'd7,  3'b000, 1'b0};  walk[7]  = '{1'b0, 4'd4,  3'b010, 1'b1};
    walk[8]  = '{1'b1, 4'd5,  3'b000, 1'b0};  walk[9]  = '{1'b1, 4'd8,  3'b001, 1'b0};
    walk[10] = '{1'b1, 4'd2,  3'b000, 1'b0};  walk[11] = '{1'b1, 4'd9,  3'b000, 1'b0};
    walk[12] = '{1'b0, 4'd10, 3'b000, 1'b0};  walk[13] = '{1'b0, 4'd11, 3'b000, 1'b1};
    walk[14] = '{1'b1, 4'd12, 3'b000, 1'b0};  walk[15] = '{1'b0, 4'd13, 3'b000, 1'b0};
    walk[16] = '{1'b1, 4'd14, 3'b000, 1'b0};  walk[17] = '{1'b0, 4'd11, 3'b000, 1'b1};
    walk[18] = '{1'b1, 4'd12, 3'b000, 1'b0};  walk[19] = '{1'b1, 4'd15, 3'b000, 1'b0};
    walk[20] = '{1'b0, 4'd1,  3'b000, 1'b0};  walk[21] = '{1'b1, 4'd2,  3'b000, 1'b0};
    walk[22] = '{1'b1, 4'd9,  3'b000, 1'b0};  walk[23] = '{1'b1, 4'd0,  3'b000, 1'b0};
    walk[24] = '{1'b0, 4'd1,  3'b000, 1'b0};  walk[25] = '{1'b1, 4'd2,  3'b000, 1'b0};
    walk[26] = '{1'b0, 4'd3,  3'b100, 1'b0};  walk[27] = '{1'b1, 4'd5,  3'b000, 1'b0};
    walk[28] = '{1'b1, 4'd8,  3'b001, 1'b0};  walk[29] = '{1'b0, 4'd1,  3'b000, 1'b0};

    TRSTN = 1'b1;
    jtag_bus.TMS = 1'b1;
    jtag_bus.TDI = 1'b0;
    user_tdo = '0;
    #2 TRSTN = 1'b0;
    #1;
    check("rst_state",   tap_state, 4'd0);
    check("rst_tdo",     jtag_bus.TDO, 1'b0);
    check("rst_tdo_en",  jtag_bus.TDO_EN, 1'b0);
    check("rst_ir",      ir, IR_RST);
    check("rst_dr_sel",  dr_sel, 2'b00);
    check("rst_strobes", {CaptureDR, ShiftDR, UpdateDR}, 3'b000);
    @(negedge TCLK);
    #1 TRSTN = 1'b1;
    @(negedge TCLK);
    #1;

    // FSM walk through all 16 states; TDI=1 so the IR passage loads 4'b1100
    for (int i = 0; i < 30; i++) begin
      step(walk[i].tms, 1'b1);
      check($sformatf("walk%0d_state", i), tap_state, walk[i].st);
      check($sformatf("walk%0d_strobes", i), {CaptureDR, ShiftDR, UpdateDR}, walk[i].strobes);
      check($sformatf("walk%0d_tdo_en", i), jtag_bus.TDO_EN, walk[i].en);
      if (i == 20) check("walk_ir_updated", ir, 4'b1100);
    end
    check("walk_ir_after_tlr", ir, IR_RST);

    for (int i = 0; i < 5; i++) step(1'b1, 1'b0);
    check("tms5_from_idle", tap_state, 4'd0);
    step(1'b0, 1'b0);

    pat = 32'h3C3C_F00F;
    dr_scan(32, pat, got, en_all, en_exit);
`ifdef TAP_IDCODE_EN
    check("idcode_read", got, IDV);
`else
    check("nocode_dr_read", got, {pat[30:0], 1'b0});
`endif
    check("dr32_en_during", en_all, 1'b1);
    check("dr32_en_exit", en_exit, 1'b0);
    pat = 32'hFFFF_0000;
    dr_scan(32, pat, got, en_all, en_exit);
`ifdef TAP_IDCODE_EN
    check("idcode_reread", got, IDV);
`else
    check("nocode_dr_reread", got, {pat[30:0], 1'b0});
`endif

    load_ir(4'b1111, cap);
    check("ir_capture", cap, 4'b0001);
    check("ir_bypass", ir, 4'b1111);
    check("bypass_dr_sel", dr_sel, 2'b00);
    pat = 32'h0000_000D;
    dr_scan(4, pat, got, en_all, en_exit);
    check("bypass_tdo", got[3:0], 4'b1010);
    check("bypass_en", en_all, 1'b1);

    load_ir(4'b0011, cap);
    check("user1_ir", ir, 4'b0011);
    check("user1_dr_sel", dr_sel, 2'b10);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    user_tdo = 2'b10;
    step(1'b0, 1'b0);
    check("user1_bit0", jtag_bus.TDO, 1'b1);
    user_tdo = 2'b01;
    step(1'b0, 1'b0);
    check("user1_bit1", jtag_bus.TDO, 1'b0);
    user_tdo = 2'b11;
    step(1'b0, 1'b0);
    check("user1_bit2", jtag_bus.TDO, 1'b1);
    user_tdo = 2'b00;
    step(1'b0, 1'b0);
    check("user1_bit3", jtag_bus.TDO, 1'b0);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);

    load_ir(4'b0010, cap);
    check("user0_dr_sel", dr_sel, 2'b01);

    load_ir(4'b0001, cap);
    check("code1_dr_sel", dr_sel, 2'b00);
    pat = 32'h1234_5678;
    dr_scan(32, pat, got, en_all, en_exit);
`ifdef TAP_IDCODE_EN
    check("code1_idcode", got, IDV);
`else
    check("code1_bypass", got, {pat[30:0], 1'b0});
`endif

    load_ir(4'b0111, cap);
    check("unknown_ir", ir, 4'b0111);
    check("unknown_dr_sel", dr_sel, 2'b00);
    user_tdo = 2'b11;
    pat = 32'h0000_0003;
    dr_scan(4, pat, got, en_all, en_exit);
    check("unknown_tdo", got[3:0], 4'b0110);
    user_tdo = 2'b00;

    // Abort a DR shift with TRSTN between clock edges
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    check("abort_pre_en", jtag_bus.TDO_EN, 1'b1);
    jtag_bus.TMS = 1'b1;
    #2 TRSTN = 1'b0;
    #1;
    check("abort_state",  tap_state, 4'd0);
    check("abort_tdo_en", jtag_bus.TDO_EN, 1'b0);
    check("abort_tdo",    jtag_bus.TDO, 1'b0);
    check("abort_ir",     ir, IR_RST);
    check("abort_strobes", {CaptureDR, ShiftDR, UpdateDR}, 3'b000);
    @(negedge TCLK);
    #1 TRSTN = 1'b1;
    step(1'b0, 1'b0);
    check("recover_idle", tap_state, 4'd1);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0);
    check("recover_tlr", tap_state, 4'd0);
    check("recover_ir", ir, IR_RST);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/tap_ctrl.md
# tap_ctrl

Parametrised IEEE 1149.1 test access port controller, the successor to the bare 16-state TAP state machine. It keeps the same state encoding and adds the parts that block left to the top level:
- an instruction register of configurable width
- instruction decode
- a bypass register and an optional IDCODE register
- one-hot selection of up to NUM_DR user data chains
- a negedge-registered TDO mux

It sits between the chip's JTAG pins and the scan/debug chains.

## Interface
- IR_W, 4: instruction register width, ≥2 and ≥ clog2(NUM_DR+3).
- NUM_DR, 2: number of user data chains, 1..8.
- IDCODE_VAL, 32'h0000_0001: device ID. Bit 0 must be 1.

Ports:
- TCLK  in  1  test clock; single clock domain.
- TRSTN  in  1  reset, asynchronous, active-low.
- TMS  in  1  mode select, sampled on posedge TCLK.
- TDI  in  1  serial data in, sampled on posedge TCLK.
- TDO  out  1  serial data out, changes on negedge TCLK.
- TDO_EN  out  1  output enable for the TDO pad driver.
- tap_state  out  4  current state: TLR=0, IDLE=1, SelectDR=2, CapDR=3, ShiDR=4, ExitDR1=5, PauseDR=6, ExitDR2=7, UpdDR=8, SelectIR=9, CapIR=10, ShiIR=11, ExitIR1=12, PauseIR=13, ExitIR2=14, UpdIR=15.
- ir  out  IR_W  active instruction.
- dr_sel  out  NUM_DR  one-hot user chain select. All zero when no USER instruction is active.
- CaptureDR, ShiftDR, UpdateDR  out  1 each  decoded from tap_state; asserted for states 3, 4, 8.
- user_tdo  in  NUM_DR  serial outputs of the user chains.

## Operation
- FSM: standard 1149.1 transitions. Five consecutive TMS=1 clocks reach TLR from any state. Any illegal state decode goes to TLR.
- Instructions:
  - BYPASS is all ones.
  - IDCODE is 1.
  - USERk is 2+k.
  - Every other code behaves as BYPASS and drives dr_sel to 0.
- IR shift register (ir_sr, IR_W bits):
  - CapIR: loads {0…0,01}.
  - ShiIR: shifts right; TDI enters the MSB and the LSB feeds TDO.
- ir update:
  - ir loads ir_sr on negedge TCLK while in UpdIR.
  - In TLR, ir is forced to its reset value: IDCODE, or BYPASS when IDCODE is compiled out.
  - dr_sel is decoded combinationally from ir.
- Bypass register, 1 bit: CapDR loads 0; ShiDR loads TDI.
- IDCODE register, 32 bits: CapDR loads IDCODE_VAL; ShiDR shifts right with TDI entering the MSB.
- DR-path TDO source:
  - IDCODE: idcode[0]
  - USERk: user_tdo[k]
  - otherwise: bypass bit.
- IR-path TDO source: ir_sr[0].
- The serial registers load and shift on posedge TCLK only, and only when their instruction is selected. Bypass always captures and shifts.

## Timing
- Async reset (TRSTN=0) sets, immediately:
  - tap_state=0, ir=reset value, ir_sr=0, bypass=0
  - TDO=0, TDO_EN=0
  - dr_sel per the reset ir.
- The idcode register is not reset; it is reloaded at CapDR.
- FSM state changes on posedge TCLK.
- CaptureDR, ShiftDR and UpdateDR follow tap_state combinationally, with no added latency.
- TDO and TDO_EN are registered on negedge TCLK.
  - TDO_EN=1 exactly while tap_state is ShiDR or ShiIR.
  - Otherwise TDO holds its last value and TDO_EN=0.
- First TDO bit: valid on the negedge after the posedge that enters ShiDR/ShiIR. It equals the captured bit 0.
- TRSTN asserted mid-shift:
  - aborts immediately
  - no UpdateDR/UpdateIR pulse
  - ir reverts to its reset value, not to the partially shifted ir_sr.
- TRSTN deassertion is synchronised externally; this block adds no synchroniser.

## Configuration
- TAP_IDCODE_EN defined (default build):
  - IDCODE register and instruction present.
  - ir resets to IDCODE.
- TAP_IDCODE_EN undefined:
  - no 32-bit register is built.
  - code 1 decodes as BYPASS.
  - ir resets to all ones.
  - A DR scan after reset returns 0 then TDI delayed by one cycle.

## Test plan
- Reset and recovery: TRSTN pulse low mid-ShiDR → tap_state=0, TDO_EN=0, ir=4'b0001 at once. Then from IDLE apply TMS=1 ×5 → tap_state=0.
- IDCODE read (IDCODE_VAL=32'hA5A5_1235): reset, TMS 0,1,0,0 → ShiDR. Shift 32 bits → TDO yields 32'hA5A5_1235 LSB first, TDO_EN=1 throughout.
- IR capture/load: go to ShiIR and shift in 4'b1111 → TDO yields 1,0,0,0. After UpdIR, ir=4'b1111 and dr_sel=0.
- Bypass: with ir=BYPASS, shift DR with TDI=1,0,1,1 → TDO=0,1,0,1.
- USER1 (NUM_DR=2): load ir=4'b0011 → dr_sel=2'b10. Toggle user_tdo[1] during ShiDR → TDO mirrors it one half-cycle later. user_tdo[0] is ignored.
- Unknown code and compile-out: load ir=4'b0111 → behaves as BYPASS with dr_sel=0. Rebuild without TAP_IDCODE_EN → after reset ir=4'b1111 and the first DR bit is 0.
